// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption: one Feistel round per clock, subkeys K16..K1 from right rotations.
// Optional DES_KEY_PARITY_CHECK_EN adds key_par_err (odd-parity check of each key byte on accept).
module des_decrypt_iter #(
  parameter int NROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:64] key,
  input  logic [1:64] cipher,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:64] plain,
  output logic        busy
`ifdef DES_KEY_PARITY_CHECK_EN
  ,
  output logic        key_par_err
`endif
);

  localparam logic [3:0] LAST = 4'(NROUNDS - 1);

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  // Parity bits 8,16,...,64 never appear here, so they cannot affect the key schedule.
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Flat S-box ROM indexed by {box, row, column}.
  localparam logic [3:0] SBOX [512] = '{
    14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
     0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
     4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
    15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
    15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
     3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
     0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
    13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
    10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
    13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
     1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
     7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
    13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
    10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
     3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
     2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
    14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
     4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
    11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
    12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
    10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
     9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
     4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
     4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
    13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
     1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
     6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
    13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
     1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
     7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
     2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11
  };

  function automatic logic [1:64] ip_perm(input logic [1:64] x);
    logic [1:64] y;
    for (int i = 0; i < 64; i++) y[i+1] = x[IP_T[i]];
    return y;
  endfunction

  function automatic logic [1:64] fp_perm(input logic [1:64] x);
    logic [1:64] y;
    for (int i = 0; i < 64; i++) y[i+1] = x[FP_T[i]];
    return y;
  endfunction

  function automatic logic [1:56] pc1_perm(input logic [1:64] x);
    logic [1:56] y;
    for (int i = 0; i < 56; i++) y[i+1] = x[PC1_T[i]];
    return y;
  endfunction

  function automatic logic [1:48] pc2_perm(input logic [1:56] x);
    logic [1:48] y;
    for (int i = 0; i < 48; i++) y[i+1] = x[PC2_T[i]];
    return y;
  endfunction

  function automatic logic [1:32] feistel(input logic [1:32] r, input logic [1:48] k);
    logic [1:48] e;
    logic [1:32] s_out;
    logic [1:32] y;
    logic [1:6]  g;
    for (int i = 0; i < 48; i++) e[i+1] = r[E_T[i]];
    e = e ^ k;
    for (int s = 0; s < 8; s++) begin
      g = e[6*s+1 +: 6];
      s_out[4*s+1 +: 4] = SBOX[{3'(s), g[1], g[6], g[2:5]}];
    end
    for (int i = 0; i < 32; i++) y[i+1] = s_out[P_T[i]];
    return y;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [1:32] l_q, r_q;
  logic [1:28] c_q, d_q;
  logic [1:28] c_rot, d_rot;
  logic [1:48] subkey;
  logic [1:32] r_next;
  logic        last_round;

  assign last_round = (cnt_q == LAST);

  // C16/D16 equal C0/D0, so the first decrypt round uses the unrotated halves.
  always_comb begin
    c_rot = c_q;
    d_rot = d_q;
    if (cnt_q == 4'd1 || cnt_q == 4'd8 || cnt_q == 4'd15) begin
      c_rot = {c_q[28], c_q[1:27]};
      d_rot = {d_q[28], d_q[1:27]};
    end else if (cnt_q != 4'd0) begin
      c_rot = {c_q[27:28], c_q[1:26]};
      d_rot = {d_q[27:28], d_q[1:26]};
    end
  end

  assign subkey = pc2_perm({c_rot, d_rot});
  assign r_next = l_q ^ feistel(r_q, subkey);

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ROUND;
      end
      ROUND: begin
        busy = 1'b1;
        if (last_round) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      l_q       <= '0;
      r_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      plain     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            {l_q, r_q} <= ip_perm(cipher);
            {c_q, d_q} <= pc1_perm(key);
            cnt_q      <= '0;
          end
        end
        ROUND: begin
          l_q   <= r_q;
          r_q   <= r_next;
          c_q   <= c_rot;
          d_q   <= d_rot;
          cnt_q <= cnt_q + 4'd1;
          if (last_round) begin
            // Final round output is swapped before the inverse permutation.
            plain     <= fp_perm({r_next, r_q});
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  logic par_bad;

  always_comb begin
    par_bad = 1'b0;
    for (int b = 0; b < 8; b++) par_bad = par_bad | ~(^key[8*b+1 +: 8]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             key_par_err <= 1'b0;
    else if (state_q == IDLE && in_valid) key_par_err <= par_bad;
  end
`endif

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Directed self-checking bench for des_decrypt_iter using published DES known-answer vectors.
// Build with DES_KEY_PARITY_CHECK_EN defined to also exercise key_par_err.
module tb_des_decrypt_iter;

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] C2 = 64'h0000000000000000;
  localparam logic [63:0] P2 = 64'h8787878787878787;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:64] key = '0;
  logic [1:64] cipher = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:64] plain;
  logic        busy;
`ifdef DES_KEY_PARITY_CHECK_EN
  logic        key_par_err;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  des_decrypt_iter #(.NROUNDS(16)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .key(key),
    .cipher(cipher),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .plain(plain),
    .busy(busy)
`ifdef DES_KEY_PARITY_CHECK_EN
    ,
    .key_par_err(key_par_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Drives one block and returns at the falling edge after the accepting edge; inputs scrambled afterwards.
  task automatic accept_block(input logic [63:0] k, input logic [63:0] c, output bit ok);
    int n;
    key = k;
    cipher = c;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    key = 64'hDEADBEEFCAFEF00D;
    cipher = 64'hA5A5A5A55A5A5A5A;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || plain !== 64'h0) begin
      errors++;
      $display("FAIL reset_outputs: out_valid=%b busy=%b plain=%h, expected 0 0 0", out_valid, busy, plain);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_known_vector();
    bit ok;
    int lat;
    accept_block(K1, C1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL kv_accept: in_ready never seen, expected 1");
    end
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL kv_busy: busy=%b in_ready=%b expected 1 0", busy, in_ready);
    end
    wait_out(lat);
    checks++;
    if (lat != 16) begin
      errors++;
      $display("FAIL kv_latency: got %0d expected 16", lat);
    end
    checks++;
    if (plain !== P1) begin
      errors++;
      $display("FAIL kv_plain: got %h expected %h", plain, P1);
    end
    release_out();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL kv_release: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_second_vector();
    bit ok;
    int lat;
    accept_block(K2, C2, ok);
    wait_out(lat);
    checks++;
    if (!ok || lat != 16) begin
      errors++;
      $display("FAIL v2_latency: ok=%b lat=%0d expected 1 16", ok, lat);
    end
    checks++;
    if (plain !== P2) begin
      errors++;
      $display("FAIL v2_plain: got %h expected %h", plain, P2);
    end
    release_out();
    repeat (3) @(negedge clk);
    checks++;
    if (plain !== P2 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL v2_hold: plain=%h out_valid=%b expected %h 0", plain, out_valid, P2);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    int bad;
    accept_block(K1, C1, ok);
    wait_out(lat);
    checks++;
    if (!ok || lat != 16) begin
      errors++;
      $display("FAIL bp_latency: ok=%b lat=%0d expected 1 16", ok, lat);
    end
    key = K2;
    cipher = C2;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || plain !== P1 || in_ready !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d unstable cycles, expected 0 (plain=%h)", bad, plain);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_next_accept: busy=%b expected 1", busy);
    end
    wait_out(lat);
    checks++;
    if (lat != 16 || plain !== P2) begin
      errors++;
      $display("FAIL bp_next_block: lat=%0d plain=%h expected 16 %h", lat, plain, P2);
    end
    release_out();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int lat;
    int seen;
    accept_block(K2, C2, ok);
    repeat (7) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rm_busy: got %b expected 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || plain !== 64'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rm_clear: out_valid=%b plain=%h busy=%b expected 0 0 0", out_valid, plain, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rm_in_ready: got %b expected 1", in_ready);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rm_no_output: out_valid high %0d cycles, expected 0", seen);
    end
    accept_block(K1, C1, ok);
    wait_out(lat);
    checks++;
    if (!ok || lat != 16 || plain !== P1) begin
      errors++;
      $display("FAIL rm_rerun: lat=%0d plain=%h expected 16 %h", lat, plain, P1);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [63:0] bk [3];
    logic [63:0] bc [3];
    logic [63:0] bp [3];
    int lat;
    int acc;
    int prev;
    int n;
    bk = '{64'h0123456789ABCDEF, 64'h0101010101010101, 64'hFEFEFEFEFEFEFEFE};
    bc = '{64'h3FA40E8A984D4815, 64'h95F8A5E5DD31D900, 64'h7359B2163E4EDC58};
    bp = '{64'h4E6F772069732074, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF};
    prev = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    key = bk[0];
    cipher = bc[0];
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!in_ready && n < 64) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready_%0d: in_ready=%b expected 1", i, in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      acc = cyc;
      if (i < 2) begin
        key = bk[i+1];
        cipher = bc[i+1];
      end else begin
        in_valid = 1'b0;
      end
      if (i > 0) begin
        checks++;
        if (acc - prev != 18) begin
          errors++;
          $display("FAIL b2b_spacing_%0d: got %0d cycles expected 18", i, acc - prev);
        end
      end
      prev = acc;
      wait_out(lat);
      checks++;
      if (lat != 16 || plain !== bp[i]) begin
        errors++;
        $display("FAIL b2b_plain_%0d: lat=%0d plain=%h expected 16 %h", i, lat, plain, bp[i]);
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

`ifdef DES_KEY_PARITY_CHECK_EN
  task automatic test_key_parity();
    bit ok;
    int lat;
    accept_block(64'h133457799BBCDFF0, C1, ok);
    checks++;
    if (key_par_err !== 1'b1) begin
      errors++;
      $display("FAIL par_bad_key: got %b expected 1", key_par_err);
    end
    wait_out(lat);
    checks++;
    if (plain !== P1 || key_par_err !== 1'b1) begin
      errors++;
      $display("FAIL par_bad_plain: plain=%h err=%b expected %h 1", plain, key_par_err, P1);
    end
    release_out();
    accept_block(K1, C1, ok);
    checks++;
    if (key_par_err !== 1'b0) begin
      errors++;
      $display("FAIL par_good_key: got %b expected 0", key_par_err);
    end
    wait_out(lat);
    release_out();
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_known_vector();
    test_second_vector();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef DES_KEY_PARITY_CHECK_EN
    test_key_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
